buf_slot_alloc: RTL and testbench

Buffer-slot allocator and round-robin scheduler for a router input port's shared packet buffer. It owns the free list of physical buffer indices and grants one free slot index per cycle to one of NREQ requesters (virtual channels) in round-robin order. It accepts released indices back into the pool. Its grant and release outputs drive the write/read index lookups of the port's FIFO index map.

---
 rtl/buf_slot_alloc.sv | 149 ++++++++++++++
 tb/tb_buf_slot_alloc.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/buf_slot_alloc.sv
// buf_slot_alloc: shared packet-buffer slot allocator for a router input port.
// Keeps a circular free list of slot indices and hands one slot per cycle to
// one of NREQ requesters in round-robin order. Released slots go back to the
// tail of the free list, so slots are re-granted in the order they came back.
// An allocation bitmap rejects releases of slots that are not currently held.
module buf_slot_alloc #(
   parameter int NREQ   = 4,
   parameter int DEPTH  = 3,
   parameter int PTR_SZ = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   gnt,
   output logic [PTR_SZ-1:0] gnt_idx,
   input  logic              rel_valid,
   input  logic [PTR_SZ-1:0] rel_idx,
   output logic              rel_err,
   output logic [PTR_SZ:0]   free_cnt,
   output logic              empty
);

   localparam int RRW = $clog2(NREQ);
   localparam logic [PTR_SZ-1:0] LAST_SLOT = PTR_SZ'(DEPTH - 1);
   localparam logic [RRW-1:0]    LAST_REQ  = RRW'(NREQ - 1);
   localparam logic [PTR_SZ:0]   FULL_CNT  = (PTR_SZ + 1)'(DEPTH);

   // Free-list pointer increment, wrapping at DEPTH (DEPTH need not be a power of two).
   function automatic logic [PTR_SZ-1:0] slot_inc(input logic [PTR_SZ-1:0] p);
      return (p == LAST_SLOT) ? '0 : p + PTR_SZ'(1);
   endfunction

   // Round-robin pointer increment, wrapping at NREQ.
   function automatic logic [RRW-1:0] rr_inc(input logic [RRW-1:0] p);
      return (p == LAST_REQ) ? '0 : p + RRW'(1);
   endfunction

   logic [PTR_SZ-1:0] fl [DEPTH];
   logic [PTR_SZ-1:0] head, tail;
   logic [PTR_SZ:0]   count;
   logic [DEPTH-1:0]  bitmap;
   logic [RRW-1:0]    rr_ptr;

   logic [NREQ-1:0]   elig;
   logic [RRW-1:0]    win;
   logic              win_found;
   logic              alloc;
   logic [PTR_SZ-1:0] head_val;
   logic              rel_held;
   logic              rel_ok;
   logic [NREQ-1:0]   gnt_nxt;
   logic [DEPTH-1:0]  bitmap_nxt;

   // The requester granted last cycle is masked so a held request is not granted twice in a row.
   assign elig = req & ~gnt;

   // Round-robin search: pick the eligible requester closest at or after rr_ptr.
   always_comb begin
      int best_d;
      int d;
      win       = '0;
      win_found = 1'b0;
      best_d    = NREQ;
      for (int i = 0; i < NREQ; i++) begin
         d = (i - int'(rr_ptr) + NREQ) % NREQ;
         if (elig[i] && d < best_d) begin
            best_d    = d;
            win       = RRW'(i);
            win_found = 1'b1;
         end
      end
   end

   assign alloc = win_found && (count != '0);

   // Head-of-free-list read and release validation against the bitmap (out-of-range indices never match).
   always_comb begin
      head_val = '0;
      rel_held = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (head == PTR_SZ'(i)) head_val = fl[i];
         if (rel_idx == PTR_SZ'(i)) rel_held = bitmap[i];
      end
   end

   // A slot granted at this edge still has its bit clear, so a same-edge release of it is rejected.
   assign rel_ok = rel_valid && rel_held;

   // Next grant vector and next bitmap; alloc and release never target the same slot.
   always_comb begin
      gnt_nxt    = '0;
      bitmap_nxt = bitmap;
      for (int i = 0; i < NREQ; i++) begin
         gnt_nxt[i] = alloc && (win == RRW'(i));
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (alloc && head_val == PTR_SZ'(i)) bitmap_nxt[i] = 1'b1;
         if (rel_ok && rel_idx == PTR_SZ'(i)) bitmap_nxt[i] = 1'b0;
      end
   end

   // Free-list storage: released indices are written at the tail.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) fl[i] <= PTR_SZ'(i);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (rel_ok && tail == PTR_SZ'(i)) fl[i] <= rel_idx;
         end
      end
   end

   // Queue pointers, occupancy count, bitmap and round-robin pointer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head   <= '0;
         tail   <= '0;
         count  <= FULL_CNT;
         bitmap <= '0;
         rr_ptr <= '0;
      end else begin
         bitmap <= bitmap_nxt;
         if (alloc) begin
            head   <= slot_inc(head);
            rr_ptr <= rr_inc(win);
         end
         if (rel_ok) tail <= slot_inc(tail);
         if (alloc && !rel_ok)      count <= count - (PTR_SZ + 1)'(1);
         else if (!alloc && rel_ok) count <= count + (PTR_SZ + 1)'(1);
      end
   end

   // Registered grant outputs; gnt_idx holds its last value when nothing is granted.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt     <= '0;
         gnt_idx <= '0;
         rel_err <= 1'b0;
      end else begin
         gnt     <= gnt_nxt;
         rel_err <= rel_valid && !rel_ok;
         if (alloc) gnt_idx <= head_val;
      end
   end

   assign free_cnt = count;
   assign empty    = (count == '0);

endmodule

// File: tb/tb_buf_slot_alloc.sv
// tb_buf_slot_alloc: directed table-driven bench for buf_slot_alloc
// (NREQ=4, DEPTH=3, PTR_SZ=2) plus a hand-written mid-stream reset sequence.
module tb_buf_slot_alloc;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       rel_valid;
   logic [1:0] rel_idx;
   logic       rel_err;
   logic [2:0] free_cnt;
   logic       empty;

   int n_checks;
   int n_fail;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic       rv;
      logic [1:0] ri;
      logic [3:0] g;
      logic [1:0] gi;
      logic       e;
      logic [2:0] c;
      logic       em;
   } vec_t;

   vec_t vecs[$];

   buf_slot_alloc #(.NREQ(4), .DEPTH(3), .PTR_SZ(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx),
      .rel_valid(rel_valid),
      .rel_idx  (rel_idx),
      .rel_err  (rel_err),
      .free_cnt (free_cnt),
      .empty    (empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] gi,
                          input logic e, input logic [2:0] c, input logic em);
      chk({tag, " gnt"},      32'(gnt),      32'(g));
      chk({tag, " gnt_idx"},  32'(gnt_idx),  32'(gi));
      chk({tag, " rel_err"},  32'(rel_err),  32'(e));
      chk({tag, " free_cnt"}, 32'(free_cnt), 32'(c));
      chk({tag, " empty"},    32'(empty),    32'(em));
   endtask

   task automatic add(input logic r, input logic [3:0] rq, input logic rv, input logic [1:0] ri,
                      input logic [3:0] g, input logic [1:0] gi, input logic e,
                      input logic [2:0] c, input logic em);
      vec_t v;
      v.rst = r; v.req = rq; v.rv = rv; v.ri = ri;
      v.g = g; v.gi = gi; v.e = e; v.c = c; v.em = em;
      vecs.push_back(v);
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      req       = 4'b0000;
      rel_valid = 1'b0;
      rel_idx   = 2'd0;

      //    rst  req     rv  ri     gnt     idx  err cnt  empty
      // Single requester held: grants every other cycle until the pool drains.
      add(1, 4'b0001, 0, 2'd0, 4'b0001, 2'd0, 0, 3'd2, 0);
      add(1, 4'b0001, 0, 2'd0, 4'b0000, 2'd0, 0, 3'd2, 0);
      add(1, 4'b0001, 0, 2'd0, 4'b0001, 2'd1, 0, 3'd1, 0);
      add(1, 4'b0001, 0, 2'd0, 4'b0000, 2'd1, 0, 3'd1, 0);
      add(1, 4'b0001, 0, 2'd0, 4'b0001, 2'd2, 0, 3'd0, 1);
      add(1, 4'b0001, 0, 2'd0, 4'b0000, 2'd2, 0, 3'd0, 1);
      add(1, 4'b0001, 0, 2'd0, 4'b0000, 2'd2, 0, 3'd0, 1);
      // Empty pool: release and request at the same edge, no bypass.
      add(1, 4'b0010, 1, 2'd2, 4'b0000, 2'd2, 0, 3'd1, 0);
      add(1, 4'b0010, 0, 2'd0, 4'b0010, 2'd2, 0, 3'd0, 1);
      add(1, 4'b0000, 0, 2'd0, 4'b0000, 2'd2, 0, 3'd0, 1);
      // Double release of idx 0, then an out-of-range release.
      add(1, 4'b0000, 1, 2'd0, 4'b0000, 2'd2, 0, 3'd1, 0);
      add(1, 4'b0000, 1, 2'd0, 4'b0000, 2'd2, 1, 3'd1, 0);
      add(1, 4'b0000, 0, 2'd0, 4'b0000, 2'd2, 0, 3'd1, 0);
      add(1, 4'b0000, 1, 2'd3, 4'b0000, 2'd2, 1, 3'd1, 0);
      add(1, 4'b0000, 0, 2'd0, 4'b0000, 2'd2, 0, 3'd1, 0);
      // Bring count to 2, then simultaneous grant and release.
      add(1, 4'b0000, 1, 2'd1, 4'b0000, 2'd2, 0, 3'd2, 0);
      add(1, 4'b0100, 1, 2'd2, 4'b0100, 2'd0, 0, 3'd2, 0);
      add(1, 4'b0000, 0, 2'd0, 4'b0000, 2'd0, 0, 3'd2, 0);
      add(1, 4'b0001, 0, 2'd0, 4'b0001, 2'd1, 0, 3'd1, 0);
      add(1, 4'b0010, 0, 2'd0, 4'b0010, 2'd2, 0, 3'd0, 1);
      add(1, 4'b0000, 0, 2'd0, 4'b0000, 2'd2, 0, 3'd0, 1);
      // Reset, then all four requesting.
      add(0, 4'b0000, 0, 2'd0, 4'b0000, 2'd0, 0, 3'd3, 0);
      add(1, 4'b1111, 0, 2'd0, 4'b0001, 2'd0, 0, 3'd2, 0);
      add(1, 4'b1111, 0, 2'd0, 4'b0010, 2'd1, 0, 3'd1, 0);
      add(1, 4'b1111, 0, 2'd0, 4'b0100, 2'd2, 0, 3'd0, 1);
      add(1, 4'b1111, 0, 2'd0, 4'b0000, 2'd2, 0, 3'd0, 1);
      add(1, 4'b1111, 1, 2'd1, 4'b0000, 2'd2, 0, 3'd1, 0);
      add(1, 4'b1111, 0, 2'd0, 4'b1000, 2'd1, 0, 3'd0, 1);
      add(1, 4'b0000, 0, 2'd0, 4'b0000, 2'd1, 0, 3'd0, 1);

      // Initial reset.
      #2 rst = 1'b0;
      #2 chk_all("reset", 4'b0000, 2'd0, 1'b0, 3'd3, 1'b0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rst       = vecs[i].rst;
         req       = vecs[i].req;
         rel_valid = vecs[i].rv;
         rel_idx   = vecs[i].ri;
         @(posedge clk);
         #1;
         chk_all($sformatf("v%0d", i), vecs[i].g, vecs[i].gi, vecs[i].e, vecs[i].c, vecs[i].em);
      end

      // Mid-stream reset: free one slot, grant it, then reset while gnt is high.
      @(negedge clk);
      req = 4'b0001; rel_valid = 1'b1; rel_idx = 2'd0;
      @(posedge clk); #1;
      chk_all("mr_rel", 4'b0000, 2'd1, 1'b0, 3'd1, 1'b0);
      @(negedge clk);
      rel_valid = 1'b0;
      @(posedge clk); #1;
      chk_all("mr_gnt", 4'b0001, 2'd0, 1'b0, 3'd0, 1'b1);
      #1 rst = 1'b0;
      #1 chk_all("mr_async", 4'b0000, 2'd0, 1'b0, 3'd3, 1'b0);
      @(negedge clk);
      rst = 1'b1; req = 4'b1111;
      @(posedge clk); #1;
      chk_all("mr_after", 4'b0001, 2'd0, 1'b0, 3'd2, 1'b0);
      @(negedge clk);
      req = 4'b0000;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
